// File: rtl/hs_pkg.sv
// Shared types and defaults for the four-phase bundled-data handshake blocks
// (hs_tx today, hs_rx later).
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } hs_state_t;

  localparam int HS_SYNC_STAGES_DEFAULT = 2;
  localparam int HS_SYNC_STAGES_MIN     = 2;

  // Timer must hold 0..TIMEOUT; a disabled timeout still gets one bit.
  function automatic int hs_timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hs_tx_sync.sv
// N-flop synchronizer with asynchronous active-high reset; used for ack in
// hs_tx and for req in hs_rx.
module sync_stages
  import hs_pkg::*;
#(
  parameter int N = HS_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  // Fewer than two stages gives no metastability margin, so clamp upward.
  localparam int STAGES = (N < HS_SYNC_STAGES_MIN) ? HS_SYNC_STAGES_MIN : N;

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/hs_tx.sv
// Four-phase return-to-zero bundled-data transmitter: one word per handshake
// to a responder in another clock domain, with an optional no-ack timeout.
module hs_tx
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = HS_SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  tx_done,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int            TW         = hs_timer_width(TIMEOUT);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TIMER_MAX  = '1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  hs_state_t             state, state_next;
  logic [TW-1:0]         timer, timer_next;
  logic                  aborted, aborted_next;
  logic                  req_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  done_next;
  logic                  err_next;
  logic                  ack_s;

  sync_stages #(
    .N(SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(ack_in),
    .sync_out(ack_s)
  );

  // A stale-high ack (e.g. a late ack after an abort) holds off new words.
  assign tx_ready = (state == IDLE) && !ack_s;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      aborted     <= 1'b0;
      req_out     <= 1'b0;
      data_out    <= '0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      aborted     <= aborted_next;
      req_out     <= req_next;
      data_out    <= data_next;
      tx_done     <= done_next;
      timeout_err <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    timer_next   = timer;
    aborted_next = aborted;
    req_next     = req_out;
    data_next    = data_out;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          data_next  = tx_data;
          req_next   = 1'b1;
          timer_next = '0;
          state_next = REQ;
        end
      end

      REQ: begin
        if (timer != TIMER_MAX) begin
          timer_next = timer + 1'b1;
        end
        // An ack arriving on the timeout cycle still counts as success.
        if (ack_s) begin
          req_next     = 1'b0;
          aborted_next = 1'b0;
          state_next   = REL;
        end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
          req_next     = 1'b0;
          err_next     = 1'b1;
          aborted_next = 1'b1;
          state_next   = REL;
        end
      end

      REL: begin
        if (!ack_s) begin
          done_next  = !aborted;
          state_next = IDLE;
        end
      end

      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hs_tx.sv
// Bench for hs_tx: directed and randomized handshakes against a cycle-count
// reference model of the four-phase protocol, on TIMEOUT=16 and TIMEOUT=4 copies.
module tb_hs_tx;

  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][7:0] tx_data;
  logic [1:0]      tx_valid;
  logic [1:0]      ack_in;
  wire  [1:0]      tx_ready;
  wire  [1:0]      req_out;
  wire  [1:0][7:0] data_out;
  wire  [1:0]      tx_done;
  wire  [1:0]      timeout_err;
  wire  [1:0]      busy;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  hs_tx #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT(16)) dut16 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .req_out(req_out[0]), .data_out(data_out[0]),
    .ack_in(ack_in[0]), .tx_done(tx_done[0]), .timeout_err(timeout_err[0]),
    .busy(busy[0])
  );

  hs_tx #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .req_out(req_out[1]), .data_out(data_out[1]),
    .ack_in(ack_in[1]), .tx_done(tx_done[1]), .timeout_err(timeout_err[1]),
    .busy(busy[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One complete handshake on copy sel. The responder raises ack ack_delay
  // samples after req is first seen (never if negative) and drops it
  // rel_delay samples after both req has fallen and ack has risen.
  task automatic applyStimulus(input int sel, input logic [7:0] word,
                               input int ack_delay, input int rel_delay);
    int tmo, exp_req, req_cnt, done_cnt, err_cnt, fall_idx, ack_fall_idx, run, idx;
    bit exp_ok, ack_dropped, finished;
    tmo     = (sel == 0) ? 16 : 4;
    exp_ok  = (ack_delay >= 0) && (ack_delay + 1 + SYNC <= tmo);
    exp_req = exp_ok ? (ack_delay + 1 + SYNC) : tmo;

    for (int w = 0; w < 50 && !tx_ready[sel]; w++) @(negedge clk);
    checkOutput("ready_before", 32'(tx_ready[sel]), 1);
    tx_data[sel]  = word;
    tx_valid[sel] = 1'b1;
    @(negedge clk);
    tx_valid[sel] = 1'b0;
    tx_data[sel]  = 8'($urandom);
    checkOutput("req_rise", 32'(req_out[sel]), 1);
    checkOutput("busy_rise", 32'(busy[sel]), 1);

    req_cnt = 0; done_cnt = 0; err_cnt = 0; run = 0;
    fall_idx = -1; ack_fall_idx = -1;
    ack_dropped = (ack_delay < 0);
    finished = 1'b0;
    idx = 0;
    while (!finished && idx < 200) begin
      if (ack_in[sel]) run++; else run = 0;
      if (req_out[sel]) req_cnt++;
      else if (fall_idx < 0) fall_idx = idx;
      if (tx_done[sel]) done_cnt++;
      if (timeout_err[sel]) err_cnt++;
      checkOutput("data_hold", 32'(data_out[sel]), 32'(word));
      if (busy[sel]) checkOutput("ready_busy", 32'(tx_ready[sel]), 0);
      if (run >= SYNC) checkOutput("ready_ack", 32'(tx_ready[sel]), 0);

      if (idx == ack_delay) ack_in[sel] = 1'b1;
      if (ack_delay >= 0 && fall_idx >= 0 && idx >= ack_delay && ack_fall_idx < 0)
        ack_fall_idx = idx + rel_delay;
      if (ack_in[sel] && idx == ack_fall_idx) begin
        ack_in[sel] = 1'b0;
        ack_dropped = 1'b1;
      end

      if (ack_dropped && fall_idx >= 0 && tx_ready[sel]) finished = 1'b1;
      else begin
        @(negedge clk);
        idx++;
      end
    end
    ack_in[sel] = 1'b0;

    checkOutput("hs_req_cycles", 32'(req_cnt), 32'(exp_req));
    checkOutput("hs_done_pulses", 32'(done_cnt), exp_ok ? 1 : 0);
    checkOutput("hs_err_pulses", 32'(err_cnt), exp_ok ? 0 : 1);
    checkOutput("hs_idle", 32'(busy[sel]), 0);
    checkOutput("hs_ready", 32'(tx_ready[sel]), 1);
  endtask

  initial begin
    logic [7:0] burst [3];
    int nxt, dones;
    bit prev_req;

    reset    = 1'b1;
    tx_valid = '0;
    ack_in   = '0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("rst_req", 32'(req_out[s]), 0);
      checkOutput("rst_data", 32'(data_out[s]), 0);
      checkOutput("rst_done", 32'(tx_done[s]), 0);
      checkOutput("rst_err", 32'(timeout_err[s]), 0);
      checkOutput("rst_busy", 32'(busy[s]), 0);
      checkOutput("rst_ready", 32'(tx_ready[s]), 1);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic transfer");
    applyStimulus(0, 8'hA5, 1, 1);

    $display("[TB] back-to-back");
    burst[0] = 8'h01; burst[1] = 8'h02; burst[2] = 8'h03;
    nxt = 0; dones = 0; prev_req = 1'b0;
    tx_data[0]  = burst[0];
    tx_valid[0] = 1'b1;
    for (int i = 0; i < 200 && !(nxt == 3 && dones == 3 && tx_ready[0]); i++) begin
      @(negedge clk);
      if (req_out[0] && !prev_req && nxt < 3) begin
        checkOutput("b2b_data", 32'(data_out[0]), 32'(burst[nxt]));
        nxt++;
        if (nxt < 3) tx_data[0] = burst[nxt];
        else tx_valid[0] = 1'b0;
      end
      if (req_out[0] && nxt > 0) checkOutput("b2b_hold", 32'(data_out[0]), 32'(burst[nxt-1]));
      if (busy[0]) checkOutput("b2b_ready", 32'(tx_ready[0]), 0);
      if (tx_done[0]) dones++;
      ack_in[0] = prev_req;
      prev_req  = req_out[0];
    end
    tx_valid[0] = 1'b0;
    ack_in[0]   = 1'b0;
    checkOutput("b2b_count", 32'(nxt), 3);
    checkOutput("b2b_dones", 32'(dones), 3);

    $display("[TB] timeout and late ack");
    applyStimulus(0, 8'h5A, -1, 1);
    applyStimulus(0, 8'hC3, 21, 10);
    applyStimulus(0, 8'h96, 2, 2);

    $display("[TB] reset mid-handshake");
    tx_data[0]  = 8'h77;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_req", 32'(req_out[0]), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_req", 32'(req_out[0]), 0);
    checkOutput("async_data", 32'(data_out[0]), 0);
    checkOutput("async_busy", 32'(busy[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(0, 8'h3C, 1, 1);

    $display("[TB] ack coincident with timeout");
    applyStimulus(1, 8'h4B, 1, 1);
    applyStimulus(1, 8'hB4, 2, 1);

    $display("[TB] randomized handshakes");
    for (int n = 0; n < 12; n++)
      applyStimulus(0, 8'($urandom), int'($urandom_range(0, 17)), int'($urandom_range(1, 4)));
    for (int n = 0; n < 6; n++)
      applyStimulus(1, 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
